// File: rtl/arm7tdmi_mul_seq.sv
// rtl/arm7tdmi_mul_seq.sv - multiply instruction sequencer (issuing side of the multiply datapath)
//
// Purpose: sequences one decoded MUL/MLA/UMULL/UMLAL/SMULL/SMLAL. Source
// registers are read one per cycle through a single register-file read port,
// operands are presented to the multiply unit with mul_en until result_ready,
// then RdLo/RdHi are written back through a single write port with optional
// N/Z update on the final write.
// Optional feature: define ARM7_MUL_TIMING_EN to insert early-termination
// WAIT cycles (m-1) derived from the latched Rs before EXEC.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, kill                 accept instruction when idle / abandon op
//   ins_rd/rn/rs/rm             register specifiers
//   ins_long/signed/acc/s       instruction form and set-flags
//   busy, done                  op in flight / final-write pulse
//   rf_raddr, rf_rdata          register-file read port (combinational data)
//   rf_we, rf_waddr, rf_wdata   register-file write port
//   mul_en, mul_type, mul_*_o   multiply request and form
//   operand_a/b, acc_hi/lo      operands (Rm, Rs, RdHi, Rn/RdLo)
//   result_hi/lo, result_ready  multiplier result
//   neg_in, zero_in             multiplier N/Z
//   flag_we, flag_n, flag_z     N/Z update strobe and values

module arm7tdmi_mul_seq #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  logic [REG_AW-1:0] ins_rd,
  input  logic [REG_AW-1:0] ins_rn,
  input  logic [REG_AW-1:0] ins_rs,
  input  logic [REG_AW-1:0] ins_rm,
  input  logic              ins_long,
  input  logic              ins_signed,
  input  logic              ins_acc,
  input  logic              ins_s,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [31:0]       rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              mul_en,
  output logic [1:0]        mul_type,
  output logic              mul_long_o,
  output logic              mul_signed_o,
  output logic              mul_acc_o,
  output logic              mul_sf_o,
  output logic [31:0]       operand_a,
  output logic [31:0]       operand_b,
  output logic [31:0]       acc_hi,
  output logic [31:0]       acc_lo,
  input  logic [31:0]       result_hi,
  input  logic [31:0]       result_lo,
  input  logic              result_ready,
  input  logic              neg_in,
  input  logic              zero_in,
  output logic              flag_we,
  output logic              flag_n,
  output logic              flag_z
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_RM,
    S_RD_RS,
    S_RD_ACLO,
    S_RD_ACHI,
    S_WAIT,
    S_EXEC,
    S_WB_LO,
    S_WB_HI
  } state_t;

  state_t state_q, state_d;
  state_t after_rd;  // state following the last register read

  logic [REG_AW-1:0] rd_q, rn_q, rs_q, rm_q;
  logic              long_q, signed_q, acc_q, s_q;
  logic [31:0]       operand_a_q, operand_b_q, acc_hi_q, acc_lo_q;
  logic [31:0]       res_hi_q, res_lo_q;
  logic              n_q, z_q;

  wire accept = (state_q == S_IDLE) && start && !kill;

`ifdef ARM7_MUL_TIMING_EN
  logic [31:0] rs_val;
  logic        ones_ok;
  logic        need_wait;
  logic [1:0]  wait_load;  // WAIT cycles minus one
  logic [1:0]  wait_cnt_q;

  always_comb begin
    // Rs is still on rf_rdata while in RD_RS; afterwards it is latched.
    rs_val    = (state_q == S_RD_RS) ? rf_rdata : operand_b_q;
    // Unsigned long forms only terminate early on leading zeros.
    ones_ok   = !long_q || signed_q;
    need_wait = 1'b1;
    wait_load = 2'd2;
    if (rs_val[31:8] == 24'h0 || (ones_ok && rs_val[31:8] == 24'hFF_FFFF)) begin
      need_wait = 1'b0;
      wait_load = 2'd0;
    end else if (rs_val[31:16] == 16'h0 || (ones_ok && rs_val[31:16] == 16'hFFFF)) begin
      wait_load = 2'd0;
    end else if (rs_val[31:24] == 8'h0 || (ones_ok && rs_val[31:24] == 8'hFF)) begin
      wait_load = 2'd1;
    end
    after_rd = need_wait ? S_WAIT : S_EXEC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 2'd0;
    end else if (state_d == S_WAIT && state_q != S_WAIT) begin
      wait_cnt_q <= wait_load;
    end else if (state_q == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q - 2'd1;
    end
  end
`else
  always_comb after_rd = S_EXEC;
`endif

  always_comb begin
    state_d  = state_q;
    rf_raddr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = 32'h0;
    mul_en   = 1'b0;
    done     = 1'b0;
    flag_we  = 1'b0;
    if (state_q != S_IDLE && kill) begin
      // Abandon: all write/request strobes stay at their defaults.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_RD_RM;
        S_RD_RM: begin
          rf_raddr = rm_q;
          state_d  = S_RD_RS;
        end
        S_RD_RS: begin
          rf_raddr = rs_q;
          state_d  = acc_q ? S_RD_ACLO : after_rd;
        end
        S_RD_ACLO: begin
          rf_raddr = rn_q;
          state_d  = long_q ? S_RD_ACHI : after_rd;
        end
        S_RD_ACHI: begin
          rf_raddr = rd_q;
          state_d  = after_rd;
        end
        S_WAIT: begin
`ifdef ARM7_MUL_TIMING_EN
          if (wait_cnt_q == 2'd0) state_d = S_EXEC;
`else
          state_d = S_EXEC;
`endif
        end
        S_EXEC: begin
          mul_en = 1'b1;
          if (result_ready) state_d = S_WB_LO;
        end
        S_WB_LO: begin
          rf_we    = 1'b1;
          rf_wdata = res_lo_q;
          if (long_q) begin
            rf_waddr = rn_q;
            state_d  = S_WB_HI;
          end else begin
            rf_waddr = rd_q;
            done     = 1'b1;
            flag_we  = s_q;
            state_d  = S_IDLE;
          end
        end
        S_WB_HI: begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = res_hi_q;
          done     = 1'b1;
          flag_we  = s_q;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      rn_q        <= '0;
      rs_q        <= '0;
      rm_q        <= '0;
      long_q      <= 1'b0;
      signed_q    <= 1'b0;
      acc_q       <= 1'b0;
      s_q         <= 1'b0;
      operand_a_q <= 32'h0;
      operand_b_q <= 32'h0;
      acc_hi_q    <= 32'h0;
      acc_lo_q    <= 32'h0;
      res_hi_q    <= 32'h0;
      res_lo_q    <= 32'h0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q     <= ins_rd;
        rn_q     <= ins_rn;
        rs_q     <= ins_rs;
        rm_q     <= ins_rm;
        long_q   <= ins_long;
        signed_q <= ins_signed;
        acc_q    <= ins_acc;
        s_q      <= ins_s;
      end
      if (!kill) begin
        case (state_q)
          S_RD_RM:   operand_a_q <= rf_rdata;
          S_RD_RS:   operand_b_q <= rf_rdata;
          S_RD_ACLO: acc_lo_q    <= rf_rdata;
          S_RD_ACHI: acc_hi_q    <= rf_rdata;
          S_EXEC: begin
            if (result_ready) begin
              res_hi_q <= result_hi;
              res_lo_q <= result_lo;
              n_q      <= neg_in;
              z_q      <= zero_in;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mul_type     = {long_q, acc_q};
  assign mul_long_o   = long_q;
  assign mul_signed_o = signed_q;
  assign mul_acc_o    = acc_q;
  assign mul_sf_o     = s_q;
  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign acc_hi       = acc_hi_q;
  assign acc_lo       = acc_lo_q;
  assign flag_n       = flag_we & n_q;
  assign flag_z       = flag_we & z_q;

endmodule

// File: tb/tb_arm7tdmi_mul_seq.sv
// tb/tb_arm7tdmi_mul_seq.sv - self-checking bench for arm7tdmi_mul_seq

module tb_arm7tdmi_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, kill;
  logic [3:0]  ins_rd, ins_rn, ins_rs, ins_rm;
  logic        ins_long, ins_signed, ins_acc, ins_s;
  logic        busy, done;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_we;
  logic        mul_en;
  logic [1:0]  mul_type;
  logic        mul_long_o, mul_signed_o, mul_acc_o, mul_sf_o;
  logic [31:0] operand_a, operand_b, acc_hi, acc_lo;
  logic [31:0] result_hi, result_lo;
  logic        result_ready, neg_in, zero_in;
  logic        flag_we, flag_n, flag_z;

  always #5 clk = ~clk;

  arm7tdmi_mul_seq #(.REG_AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill),
    .ins_rd(ins_rd), .ins_rn(ins_rn), .ins_rs(ins_rs), .ins_rm(ins_rm),
    .ins_long(ins_long), .ins_signed(ins_signed), .ins_acc(ins_acc), .ins_s(ins_s),
    .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mul_en(mul_en), .mul_type(mul_type),
    .mul_long_o(mul_long_o), .mul_signed_o(mul_signed_o),
    .mul_acc_o(mul_acc_o), .mul_sf_o(mul_sf_o),
    .operand_a(operand_a), .operand_b(operand_b), .acc_hi(acc_hi), .acc_lo(acc_lo),
    .result_hi(result_hi), .result_lo(result_lo), .result_ready(result_ready),
    .neg_in(neg_in), .zero_in(zero_in),
    .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z)
  );

  // Register file seen by the DUT, and the bench's own expectation of it.
  logic [31:0] regs  [16];
  logic [31:0] model [16];
  assign rf_rdata = regs[rf_raddr];

  // Multiply unit stand-in: result_ready after mul_delay extra EXEC cycles;
  // random noise on result_ready whenever no request is pending.
  int   mul_delay;
  int   exec_cnt;
  logic junk_q;
  logic [63:0] mprod;

  always @(posedge clk or posedge rst)
    if (rst) exec_cnt <= 0;
    else if (mul_en && !result_ready) exec_cnt <= exec_cnt + 1;
    else exec_cnt <= 0;

  always @(negedge clk) junk_q <= 1'($urandom_range(0, 1));

  assign result_ready = mul_en ? (exec_cnt >= mul_delay) : junk_q;

  always_comb begin
    if (mul_long_o && mul_signed_o)
      mprod = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
    else
      mprod = {32'h0, operand_a} * {32'h0, operand_b};
    if (mul_acc_o) mprod = mprod + (mul_long_o ? {acc_hi, acc_lo} : {32'h0, acc_lo});
  end
  assign result_lo = mprod[31:0];
  assign result_hi = mprod[63:32];
  assign neg_in    = mul_long_o ? mprod[63] : mprod[31];
  assign zero_in   = mul_long_o ? (mprod == 64'h0) : (mprod[31:0] == 32'h0);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    regs[i]  = v;
    model[i] = v;
  endtask

  // Early-termination WAIT cycles for the timing build.
  function automatic int wait_cycles(input logic [31:0] v, input logic ones_ok);
    if (v < 32'h100 || (ones_ok && v >= 32'hFFFF_FF00)) return 0;
    if (v < 32'h1_0000 || (ones_ok && v >= 32'hFFFF_0000)) return 1;
    if (v < 32'h100_0000 || (ones_ok && v >= 32'hFF00_0000)) return 2;
    return 3;
  endfunction

  task automatic scramble_ins();
    ins_rd = 4'($urandom); ins_rn = 4'($urandom);
    ins_rs = 4'($urandom); ins_rm = 4'($urandom);
    ins_long = 1'($urandom); ins_signed = 1'($urandom);
    ins_acc = 1'($urandom); ins_s = 1'($urandom);
  endtask

  // Issue one instruction at the current negedge and check everything it does.
  task automatic run_op(input string nm, input logic [3:0] rd, rn, rs, rm,
                        input logic lng, sgn, acc, s, input int dly);
    longint          sm, ss;
    longint unsigned um, us, full;
    logic [31:0]     lo, hi, a0, b0, h0, l0;
    logic [1:0]      t0;
    logic [3:0]      ea[$], ga[$];
    logic [31:0]     ed[$], gd[$];
    logic            exp_n, exp_z, fwe, fn, fz, en_seen;
    int              lat, cyc, done_cyc, en_cnt;

    if (lng) begin
      sm = $signed(model[rm]);
      ss = $signed(model[rs]);
      um = model[rm];
      us = model[rs];
      full = sgn ? longint'(sm * ss) : um * us;
      if (acc) full = full + {model[rd], model[rn]};
      lo = full[31:0];
      hi = full[63:32];
      ea.push_back(rn); ed.push_back(lo);
      ea.push_back(rd); ed.push_back(hi);
      exp_n = hi[31];
      exp_z = (full == 0);
    end else begin
      lo = model[rm] * model[rs] + (acc ? model[rn] : 32'h0);
      ea.push_back(rd); ed.push_back(lo);
      exp_n = lo[31];
      exp_z = (lo == 32'h0);
    end
    lat = 4 + int'(acc) + int'(lng) + int'(acc && lng) + dly;
`ifdef ARM7_MUL_TIMING_EN
    lat += wait_cycles(model[rs], !lng || sgn);
`endif

    mul_delay = dly;
    kill = 1'b0;
    ins_rd = rd; ins_rn = rn; ins_rs = rs; ins_rm = rm;
    ins_long = lng; ins_signed = sgn; ins_acc = acc; ins_s = s;
    start = 1'b1;
    cyc = 0; done_cyc = -1; en_cnt = 0; en_seen = 1'b0;
    fwe = 1'b0; fn = 1'b0; fz = 1'b0;
    a0 = '0; b0 = '0; h0 = '0; l0 = '0; t0 = '0;

    while (cyc < lat + 20 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (rf_we) begin
        ga.push_back(rf_waddr);
        gd.push_back(rf_wdata);
        regs[rf_waddr] = rf_wdata;
      end
      if (mul_en) begin
        if (!en_seen) begin
          en_seen = 1'b1;
          a0 = operand_a; b0 = operand_b; h0 = acc_hi; l0 = acc_lo; t0 = mul_type;
        end else begin
          check({nm, " hold_a"}, operand_a, a0);
          check({nm, " hold_b"}, operand_b, b0);
          check({nm, " hold_acc"}, {acc_hi, acc_lo}, {h0, l0});
          check({nm, " hold_type"}, mul_type, t0);
        end
        en_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        fwe = flag_we; fn = flag_n; fz = flag_z;
        start = 1'b0;
      end else begin
        // Requests while busy must be ignored.
        start = 1'($urandom_range(0, 1));
        scramble_ins();
      end
    end
    start = 1'b0;

    if (done_cyc < 0) check({nm, " timeout"}, 0, 1);
    check({nm, " done_cycle"}, done_cyc, lat);
    check({nm, " n_writes"}, ga.size(), ea.size());
    for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
      check({nm, " waddr"}, ga[i], ea[i]);
      check({nm, " wdata"}, gd[i], ed[i]);
    end
    check({nm, " mul_en_cycles"}, en_cnt, dly + 1);
    check({nm, " mul_type"}, t0, {lng, acc});
    check({nm, " operand_a"}, a0, model[rm]);
    check({nm, " operand_b"}, b0, model[rs]);
    if (acc) check({nm, " acc_lo"}, l0, model[rn]);
    if (acc && lng) check({nm, " acc_hi"}, h0, model[rd]);
    check({nm, " flag_we"}, fwe, s);
    if (s) check({nm, " flags_nz"}, {fn, fz}, {exp_n, exp_z});

    for (int i = 0; i < ea.size(); i++) model[ea[i]] = ed[i];
    @(negedge clk);
    check({nm, " busy_after"}, busy, 0);
    check({nm, " reg_rd"}, regs[rd], model[rd]);
    check({nm, " reg_rn"}, regs[rn], model[rn]);
  endtask

  // Count strobes that must stay quiet over n cycles.
  task automatic quiet_cycles(input string nm, input int n);
    int ev = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rf_we || done || mul_en || flag_we || busy) ev++;
    end
    check({nm, " quiet"}, ev, 0);
  endtask

  initial begin
    logic [31:0] pat;
    logic [3:0]  r_rd, r_rn, r_rs, r_rm;

    rst = 1'b1; start = 1'b0; kill = 1'b0; mul_delay = 0;
    ins_rd = '0; ins_rn = '0; ins_rs = '0; ins_rm = '0;
    ins_long = 1'b0; ins_signed = 1'b0; ins_acc = 1'b0; ins_s = 1'b0;
    for (int i = 0; i < 16; i++) set_reg(i, $urandom);
    repeat (2) @(negedge clk);
    check("rst busy_done_we_en", {busy, done, rf_we, mul_en, flag_we}, 5'b0);
    check("rst operands", {operand_a, operand_b}, 64'h0);
    check("rst acc", {acc_hi, acc_lo}, 64'h0);
    check("rst type_addr", {mul_type, rf_raddr, rf_waddr, flag_n, flag_z}, 12'h0);
    rst = 1'b0;

    // Directed cases.
    set_reg(1, 32'd7); set_reg(6, 32'd6);
    run_op("mul", 4'd2, 4'd0, 4'd6, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("mul r2", regs[2], 32'h0000_002A);
    set_reg(7, 32'hFFFF_FFFF); set_reg(8, 32'd1); set_reg(9, 32'd1);
    run_op("mla_s", 4'd3, 4'd9, 4'd8, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check("mla r3", regs[3], 32'h0);
    set_reg(10, 32'hFFFF_FFFE); set_reg(11, 32'd3);
    run_op("smull", 4'd5, 4'd4, 4'd11, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("smull r4r5", {regs[5], regs[4]}, 64'hFFFF_FFFF_FFFF_FFFA);
    set_reg(12, 32'hFFFF_FFFF); set_reg(13, 32'd2); set_reg(6, 32'hFFFF_FFFF); set_reg(7, 32'd1);
    run_op("umlal", 4'd7, 4'd6, 4'd13, 4'd12, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    check("umlal r6r7", {regs[7], regs[6]}, 64'h0000_0003_FFFF_FFFD);
    set_reg(1, 32'h1234_5678); set_reg(2, 32'h0001_0000);
    run_op("same_hilo", 4'd8, 4'd8, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    check("same_hilo r8", regs[8], 32'h0000_1234);
    set_reg(3, 32'h0001_2345);
    run_op("mul_rs_mid", 4'd9, 4'd0, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    set_reg(3, 32'hFFFF_FF80);
    run_op("mul_rs_neg", 4'd9, 4'd0, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_op("umull_rs_neg", 4'd11, 4'd10, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 0);

    // kill in RD_RS abandons the op.
    set_reg(2, 32'd3);
    mul_delay = 0;
    ins_rd = 4'd14; ins_rn = 4'd0; ins_rs = 4'd2; ins_rm = 4'd1;
    ins_long = 1'b0; ins_signed = 1'b0; ins_acc = 1'b0; ins_s = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); kill = 1'b1;
    check("kill in_rd_rs busy", busy, 1);
    check("kill strobes", {rf_we, done, mul_en, flag_we}, 4'b0);
    @(negedge clk); kill = 1'b0;
    check("kill busy_next", busy, 0);
    quiet_cycles("kill", 5);
    check("kill r14 untouched", regs[14], model[14]);

    // kill overrides start in IDLE.
    start = 1'b1; kill = 1'b1;
    @(negedge clk); start = 1'b0; kill = 1'b0;
    check("kill_over_start busy", busy, 0);

    // rst pulsed in EXEC.
    mul_delay = 8;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_exec mul_en", mul_en, 1);
    rst = 1'b1;
    #1;
    check("rst_exec async", {busy, mul_en, rf_we, done}, 4'b0);
    check("rst_exec operand_a", operand_a, 32'h0);
    @(negedge clk); rst = 1'b0;
    quiet_cycles("rst_exec", 5);
    check("rst_exec r14 untouched", regs[14], model[14]);
    run_op("after_rst", 4'd14, 4'd0, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Randomized mix.
    for (int k = 0; k < 40; k++) begin
      r_rd = 4'($urandom); r_rn = 4'($urandom);
      r_rs = 4'($urandom); r_rm = 4'($urandom);
      case ($urandom_range(0, 4))
        0: pat = $urandom_range(0, 255);
        1: pat = 32'hFFFF_FF00 | $urandom_range(0, 255);
        2: pat = 32'h0000_FFFF & $urandom;
        3: pat = 32'hFF00_0000 | ($urandom & 32'h00FF_FFFF);
        default: pat = $urandom;
      endcase
      set_reg(int'(r_rs), pat);
      run_op("rand", r_rd, r_rn, r_rs, r_rm, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
